// File: rtl/registro_carga_in.sv
// Input load stage: debounced load/clear buttons step operand A, operand B and the
// opcode into registers, then offer the word to the ALU over a valid/ready handshake.

module registro_carga_in_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic evt_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          deb_q;
  logic          deb_d;
  logic          deb_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The debounced level only follows s2 after DEB_CYCLES consecutive mismatched cycles.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= btn_i;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign evt_o = deb_q & ~deb_prev_q;

endmodule

module registro_carga_in #(
  parameter int N          = 4,
  parameter int OPW        = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sw_data,
  input  logic [OPW-1:0] sw_op,
  input  logic           btn_load,
  input  logic           btn_clear,
  input  logic           alu_ready,
  output logic [N-1:0]   a_out,
  output logic [N-1:0]   b_out,
  output logic [OPW-1:0] op_out,
  output logic           valid,
  output logic [1:0]     state_out,
  output logic [7:0]     op_count
);

  localparam logic [1:0] S_LOAD_A  = 2'b00;
  localparam logic [1:0] S_LOAD_B  = 2'b01;
  localparam logic [1:0] S_LOAD_OP = 2'b10;
  localparam logic [1:0] S_ISSUE   = 2'b11;

  logic           load_evt;
  logic           clear_evt;
  logic [1:0]     state_q;
  logic [1:0]     state_d;
  logic [N-1:0]   a_q;
  logic [N-1:0]   a_d;
  logic [N-1:0]   b_q;
  logic [N-1:0]   b_d;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_d;
  logic           valid_q;
  logic           valid_d;
  logic [7:0]     cnt_q;
  logic [7:0]     cnt_d;

  registro_carga_in_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_load),
    .evt_o (load_evt)
  );

  registro_carga_in_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_clear),
    .evt_o (clear_evt)
  );

  // Clear outranks the handshake, which outranks loading; loads in ISSUE are dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (clear_evt) begin
      state_d = S_LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (load_evt) begin
            a_d     = sw_data;
            state_d = S_LOAD_B;
          end else begin
            state_d = S_LOAD_A;
          end
        end
        S_LOAD_B: begin
          if (load_evt) begin
            b_d     = sw_data;
            state_d = S_LOAD_OP;
          end else begin
            state_d = S_LOAD_B;
          end
        end
        S_LOAD_OP: begin
          if (load_evt) begin
            op_d    = sw_op;
            state_d = S_ISSUE;
          end else begin
            state_d = S_LOAD_OP;
          end
        end
        S_ISSUE: begin
          if (alu_ready) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_LOAD_A;
          end else begin
            state_d = S_ISSUE;
          end
        end
        default: begin
          state_d = S_LOAD_A;
        end
      endcase
    end
    valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign op_out    = op_q;
  assign valid     = valid_q;
  assign state_out = state_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_registro_carga_in.sv
// Randomized bench for registro_carga_in: an abstract phase/field model feeds
// expected words into queues that a negedge monitor checks on valid transitions.

module tb_registro_carga_in;

  localparam int N   = 4;
  localparam int OPW = 4;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;
  localparam int SNW = 2 + 2 * N + OPW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   sw_data = '0;
  logic [OPW-1:0] sw_op = '0;
  logic           btn_load = 1'b0;
  logic           btn_clear = 1'b0;
  logic           alu_ready = 1'b0;
  logic [N-1:0]   a_out;
  logic [N-1:0]   b_out;
  logic [OPW-1:0] op_out;
  logic           valid;
  logic [1:0]     state_out;
  logic [7:0]     op_count;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [OPW-1:0] op;
    logic [7:0]     cnt;
  } word_t;

  word_t rise_q[$];
  word_t fall_q[$];

  // Reference model: phase 0..2 = next field to load, 3 = word on offer.
  int             m_phase = 0;
  logic [N-1:0]   m_a = '0;
  logic [N-1:0]   m_b = '0;
  logic [OPW-1:0] m_op = '0;
  int             m_cnt = 0;

  registro_carga_in #(.N(N), .OPW(OPW), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_data   (sw_data),
    .sw_op     (sw_op),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .alu_ready (alu_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_out    (op_out),
    .valid     (valid),
    .state_out (state_out),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t cur();
    word_t w;
    w.a   = m_a;
    w.b   = m_b;
    w.op  = m_op;
    w.cnt = m_cnt[7:0];
    return w;
  endfunction

  task automatic m_load(input logic [N-1:0] d, input logic [OPW-1:0] o);
    case (m_phase)
      0: begin m_a = d; m_phase = 1; end
      1: begin m_b = d; m_phase = 2; end
      2: begin m_op = o; m_phase = 3; rise_q.push_back(cur()); end
      default: ;
    endcase
  endtask

  task automatic m_handshake();
    if (m_phase == 3) begin
      m_cnt   = (m_cnt + 1) % 256;
      m_phase = 0;
      fall_q.push_back(cur());
    end
  endtask

  task automatic m_clear();
    bit was_issue;
    was_issue = (m_phase == 3);
    m_a = '0; m_b = '0; m_op = '0; m_phase = 0;
    if (was_issue) fall_q.push_back(cur());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a button for `hold` edges, lets the release debounce, and reports the
  // first edge (counted from the first one sampling the press) that changed outputs.
  task automatic press(input bit clr, input int hold, input int ready_edge,
                       input bit rnd_ready, output int edge_at);
    logic [SNW-1:0] snap0;
    snap0   = {state_out, a_out, b_out, op_out};
    edge_at = 0;
    if (clr) btn_clear = 1'b1; else btn_load = 1'b1;
    for (int i = 1; i <= hold + DEB + 6; i++) begin
      alu_ready = rnd_ready ? 1'($urandom_range(0, 1)) : (i == ready_edge);
      tick();
      if (i == hold) begin
        btn_load  = 1'b0;
        btn_clear = 1'b0;
      end
      if (edge_at == 0 && {state_out, a_out, b_out, op_out} !== snap0) edge_at = i;
    end
    alu_ready = 1'b0;
  endtask

  task automatic do_handshake();
    m_handshake();
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
  endtask

  // Monitor: compares the word on every rise of valid and the aftermath on every fall.
  initial begin
    logic  vprev;
    word_t w;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && vprev !== 1'b1) begin
        if (rise_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_valid: got valid=1 a=%0h b=%0h op=%0h, expected no word", a_out, b_out, op_out);
        end else begin
          w = rise_q.pop_front();
          check("issue_a", 32'(a_out), 32'(w.a));
          check("issue_b", 32'(b_out), 32'(w.b));
          check("issue_op", 32'(op_out), 32'(w.op));
          check("issue_cnt", 32'(op_count), 32'(w.cnt));
          check("issue_state", 32'(state_out), 32'd3);
        end
      end else if (valid !== 1'b1 && vprev === 1'b1) begin
        if (fall_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_drop: got valid=%b, expected valid=1", valid);
        end else begin
          w = fall_q.pop_front();
          check("done_a", 32'(a_out), 32'(w.a));
          check("done_b", 32'(b_out), 32'(w.b));
          check("done_op", 32'(op_out), 32'(w.op));
          check("done_cnt", 32'(op_count), 32'(w.cnt));
          check("done_state", 32'(state_out), 32'd0);
        end
      end
      vprev = valid;
    end
  end

  initial begin
    int e;
    logic [N-1:0]   d;
    logic [OPW-1:0] o;

    // Reset with the load button already held.
    sw_data  = 4'h3;
    btn_load = 1'b1;
    rst      = 1'b1;
    repeat (2) tick();
    check("rst_a", 32'(a_out), 32'd0);
    check("rst_b", 32'(b_out), 32'd0);
    check("rst_op", 32'(op_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_cnt", 32'(op_count), 32'd0);
    rst = 1'b0;

    m_load(4'h3, 4'h0);
    press(1'b0, 8, 0, 1'b0, e);
    check("lat_a", 32'(e), 32'(LAT));
    sw_data = 4'h5;
    m_load(4'h5, 4'h0);
    press(1'b0, 8, 0, 1'b0, e);
    check("lat_b", 32'(e), 32'(LAT));
    sw_op   = 4'h2;
    sw_data = 4'($urandom);
    m_load(sw_data, 4'h2);
    press(1'b0, 8, 0, 1'b0, e);
    check("lat_op", 32'(e), 32'(LAT));
    check("word_a", 32'(a_out), 32'h3);
    check("word_b", 32'(b_out), 32'h5);
    check("word_op", 32'(op_out), 32'h2);
    check("word_valid", 32'(valid), 32'd1);

    // Extra load press while stalled in ISSUE must be dropped.
    sw_data = 4'hA;
    sw_op   = 4'hC;
    m_load(sw_data, sw_op);
    press(1'b0, 8, 0, 1'b0, e);
    check("stall_no_change", 32'(e), 32'd0);
    repeat (5) tick();
    check("stall_valid", 32'(valid), 32'd1);
    do_handshake();
    check("hs_valid", 32'(valid), 32'd0);
    check("hs_state", 32'(state_out), 32'd0);
    check("hs_cnt", 32'(op_count), 32'd1);
    repeat (3) tick();
    check("hold_a", 32'(a_out), 32'h3);
    check("no_queued_load", 32'(state_out), 32'd0);

    // A 3-edge glitch is filtered, a 4-edge press is accepted.
    sw_data = 4'($urandom);
    press(1'b0, 3, 0, 1'b0, e);
    check("glitch", 32'(e), 32'd0);
    m_load(sw_data, sw_op);
    press(1'b0, 4, 0, 1'b0, e);
    check("short_press", 32'(e), 32'(LAT));
    check("short_a", 32'(a_out), 32'(m_a));
    sw_data = 4'($urandom);
    m_load(sw_data, sw_op);
    press(1'b0, 8, 0, 1'b0, e);

    // Clear in LOAD_OP.
    m_clear();
    press(1'b1, 8, 0, 1'b0, e);
    check("clr_lat", 32'(e), 32'(LAT));
    check("clr_state", 32'(state_out), 32'd0);
    check("clr_a", 32'(a_out), 32'd0);
    check("clr_b", 32'(b_out), 32'd0);
    check("clr_cnt", 32'(op_count), 32'(m_cnt));

    // Clear coinciding with alu_ready in ISSUE: clear wins, no count.
    for (int k = 0; k < 3; k++) begin
      sw_data = 4'($urandom);
      sw_op   = 4'($urandom);
      m_load(sw_data, sw_op);
      press(1'b0, 8, 0, 1'b0, e);
    end
    m_clear();
    press(1'b1, 8, LAT, 1'b0, e);
    check("clr_hs_state", 32'(state_out), 32'd0);
    check("clr_hs_op", 32'(op_out), 32'd0);
    check("clr_hs_cnt", 32'(op_count), 32'(m_cnt));

    // Full cycles until op_count wraps to 0.
    while (m_cnt != 0) begin
      for (int k = 0; k < 3; k++) begin
        sw_data = 4'($urandom);
        sw_op   = 4'($urandom);
        m_load(sw_data, sw_op);
        press(1'b0, 4 + $urandom_range(0, 2), 0, (k < 2), e);
        check("loop_lat", 32'(e), 32'(LAT));
      end
      repeat ($urandom_range(0, 3)) tick();
      do_handshake();
    end
    check("wrap_cnt", 32'(op_count), 32'd0);
    check("wrap_a", 32'(a_out), 32'(m_a));
    check("wrap_op", 32'(op_out), 32'(m_op));

    repeat (3) tick();
    check("rise_q_empty", 32'(rise_q.size()), 32'd0);
    check("fall_q_empty", 32'(fall_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
